// File: rtl/flag_pkg.sv
// Shared definitions for the flag loader/checker path.
// FLAG_BYTES/FLAG_W size the default flag, state_t is the loader FSM
// encoding, and fmt_match() tells whether a byte at a given position agrees
// with the "ictf{...}" wrapper (positions outside the wrapper always agree).
package flag_pkg;

  localparam int FLAG_BYTES = 32;
  localparam int FLAG_W     = 8 * FLAG_BYTES;

  typedef enum logic [1:0] {LOAD, CHECK, RESULT} state_t;

  localparam logic [39:0] FMT_PREFIX = 40'h696374667B;  // "ictf{"
  localparam logic [7:0]  FMT_SUFFIX = 8'h7D;           // "}"

  function automatic logic fmt_match(input int unsigned pos,
                                     input int unsigned nbytes,
                                     input logic [7:0]  b);
    if (pos < 5)
      return b == FMT_PREFIX[39 - 8*pos -: 8];
    else if (pos == nbytes - 1)
      return b == FMT_SUFFIX;
    else
      return 1'b1;
  endfunction

endpackage

// File: rtl/flag_byte_loader.sv
// Byte-serial front end of the flag checker.
// Packs NBYTES bytes (first byte in the MSBs) into flag_word, holds it for
// CHECK_LAT cycles while the downstream checker settles, then samples the
// checker's `wrong` vector and presents a held pass/fail + format verdict
// until res_ack.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_data/in_valid    byte stream in; in_ready = loader is in LOAD
//   flag_word/flag_valid packed flag to the checker, valid once complete
//   wrong               checker result vector, zero means correct
//   res_valid/res_pass/res_fmt_ok  verdict, held until res_ack
//   busy                not idle (mid-load, checking or holding a verdict)
module flag_byte_loader
  import flag_pkg::*;
#(
  parameter  int NBYTES    = FLAG_BYTES,
  parameter  int CHECK_LAT = 2,
  localparam int W         = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] flag_word,
  output logic         flag_valid,
  input  logic [W-1:0] wrong,
  output logic         res_valid,
  output logic         res_pass,
  output logic         res_fmt_ok,
  input  logic         res_ack,
  output logic         busy
);

  localparam int CW = (NBYTES > 1)    ? $clog2(NBYTES)    : 1;
  localparam int WW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [CW-1:0] LAST  = CW'(NBYTES - 1);
  localparam logic [WW-1:0] WLAST = WW'(CHECK_LAT - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wcnt;
  logic          acc;
  logic          hs;

  assign hs   = in_valid & in_ready;
  // Decoded from registers only; cnt sits at LAST through CHECK/RESULT.
  assign busy = (state != LOAD) || (cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (hs && cnt == LAST) state_n = CHECK;
      CHECK:   if (wcnt == WLAST)     state_n = RESULT;
      RESULT:  if (res_ack)           state_n = LOAD;
      default:                        state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready   <= 1'b0;
      cnt        <= '0;
      wcnt       <= '0;
      acc        <= 1'b1;
      flag_word  <= '0;
      flag_valid <= 1'b0;
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      res_fmt_ok <= 1'b0;
    end else begin
      // Registered copy of (state == LOAD); held low through reset.
      in_ready <= (state_n == LOAD);
      case (state)
        LOAD: if (hs) begin
          flag_word <= {flag_word[W-9:0], in_data};
          acc       <= acc & fmt_match(int'(cnt), NBYTES, in_data);
          if (cnt == LAST) begin
            flag_valid <= 1'b1;
            wcnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CHECK: begin
          wcnt <= wcnt + 1'b1;
          if (wcnt == WLAST) begin
            res_pass   <= ~|wrong;
            res_fmt_ok <= acc;
            res_valid  <= 1'b1;
          end
        end
        RESULT: if (res_ack) begin
          res_valid  <= 1'b0;
          flag_valid <= 1'b0;
          flag_word  <= '0;
          cnt        <= '0;
          acc        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flag_byte_loader.sv
// Directed-sequence bench with randomized payloads and gaps for
// flag_byte_loader. A behavioural checker model drives `wrong` from a secret
// word; expected words/verdicts come from the byte array via plain indexing.
module tb_flag_byte_loader;
  import flag_pkg::*;

  localparam int NB = 32;
  localparam int LAT = 2;
  localparam logic [255:0] HAPPY =
    256'h696374667B_41414141414141414141414141_41414141414141414141414141_7D;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] flag_word;
  logic         flag_valid;
  logic [255:0] wrong;
  logic         res_valid, res_pass, res_fmt_ok;
  logic         res_ack = 1'b0;
  logic         busy;

  logic [255:0] secret = '0;
  logic [7:0]   fb [NB];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;

  flag_byte_loader #(.NBYTES(NB), .CHECK_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flag_word(flag_word), .flag_valid(flag_valid),
    .wrong(wrong), .res_valid(res_valid), .res_pass(res_pass),
    .res_fmt_ok(res_fmt_ok), .res_ack(res_ack), .busy(busy)
  );

  // Checker model: a bit of `wrong` is set wherever the word differs.
  assign wrong = flag_word ^ secret;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [255:0] model_word();
    logic [255:0] w = '0;
    for (int i = 0; i < NB; i++) w[255 - 8*i -: 8] = fb[i];
    return w;
  endfunction

  function automatic logic model_fmt();
    return fb[0] == 8'h69 && fb[1] == 8'h63 && fb[2] == 8'h74 &&
           fb[3] == 8'h66 && fb[4] == 8'h7B && fb[NB-1] == 8'h7D;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill_happy();
    for (int i = 0; i < NB; i++) fb[i] = 8'h41;
    fb[0] = 8'h69; fb[1] = 8'h63; fb[2] = 8'h74; fb[3] = 8'h66; fb[4] = 8'h7B;
    fb[NB-1] = 8'h7D;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_in_ready"},   in_ready,   0);
    chk({tag, "_flag_word"},  flag_word,  0);
    chk({tag, "_flag_valid"}, flag_valid, 0);
    chk({tag, "_res_valid"},  res_valid,  0);
    chk({tag, "_res_pass"},   res_pass,   0);
    chk({tag, "_res_fmt"},    res_fmt_ok, 0);
    chk({tag, "_busy"},       busy,       0);
  endtask

  // Offer n bytes of fb; all driving/sampling on negedges. A byte counts as
  // taken when in_valid and in_ready are both high going into a posedge.
  task automatic send_n(input int n, input bit gaps, input bit hold, output int first_edge);
    int i = 0;
    int guard = 0;
    first_edge = -1;
    while (i < n && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = fb[i];
        if (in_ready) begin
          if (i == 0) first_edge = cyc + 1;
          i++;
        end
      end
    end
    chk("send_timeout", 1'(i == n), 1'b1);
    @(negedge clk);
    if (hold) in_data = 8'hEE;   // producer keeps offering a byte
    else      in_valid = 1'b0;
  endtask

  task automatic check_verdict(input string tag, input int first_edge, input bit b2b);
    int rise = -1;
    chk({tag, "_flag_valid"}, flag_valid, 1);
    chk({tag, "_ready_low"},  in_ready,   0);
    for (int k = 0; k < 100; k++) begin
      if (res_valid) begin rise = cyc; break; end
      @(negedge clk);
    end
    chk({tag, "_res_timeout"}, 1'(rise >= 0), 1'b1);
    if (b2b) chk({tag, "_latency"}, 256'(rise - first_edge), 256'(NB + LAT - 1));
    chk({tag, "_word"}, flag_word,  model_word());
    chk({tag, "_pass"}, res_pass,   1'(model_word() == secret));
    chk({tag, "_fmt"},  res_fmt_ok, model_fmt());
  endtask

  task automatic finish_ack(input string tag, input int hold_cycles, input bit with_valid);
    for (int k = 0; k < hold_cycles; k++) begin
      @(negedge clk);
      chk({tag, "_res_hold"}, res_valid, 1);
      chk({tag, "_word_hold"}, flag_word, model_word());
    end
    in_valid = with_valid;
    in_data  = 8'h55;
    res_ack  = 1'b1;
    @(negedge clk);
    res_ack  = 1'b0;
    in_valid = 1'b0;
    chk({tag, "_ack_res_valid"},  res_valid,  0);
    chk({tag, "_ack_flag_valid"}, flag_valid, 0);
    chk({tag, "_ack_word"},       flag_word,  0);
    chk({tag, "_ack_busy"},       busy,       0);
    chk({tag, "_ack_ready"},      in_ready,   1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check_reset_state(tag);
    rst = 1'b0;
    @(negedge clk);
    chk({tag, "_ready_after"}, in_ready, 1);
  endtask

  initial begin
    int fe;

    // Reset
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_after", in_ready, 1);

    // Ack while idle in LOAD is ignored
    res_ack = 1'b1;
    @(negedge clk);
    res_ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_busy", busy, 0);
    chk("idle_ack_ready", in_ready, 1);

    // Happy path
    fill_happy();
    secret = model_word();
    send_n(NB, 1'b0, 1'b0, fe);
    chk("happy_literal", flag_word, HAPPY);
    chk("happy_busy", busy, 1);
    check_verdict("happy", fe, 1'b1);
    finish_ack("happy", 5, 1'b0);

    // Wrong flag: 10th byte differs, checker still expects HAPPY
    fill_happy();
    fb[9] = 8'h42;
    send_n(NB, 1'b0, 1'b0, fe);
    check_verdict("wrongflag", fe, 1'b1);
    chk("wrongflag_outside", wrong & ~(256'hFF << 176), 0);
    chk("wrongflag_inside_nz", 1'(wrong[183:176] != 8'h00), 1'b1);
    finish_ack("wrongflag", 1, 1'b0);

    // Bad format, checker expects this very word
    fill_happy();
    fb[0] = 8'h49;
    fb[NB-1] = 8'h21;
    secret = model_word();
    send_n(NB, 1'b0, 1'b0, fe);
    check_verdict("badfmt", fe, 1'b1);
    finish_ack("badfmt", 2, 1'b0);

    // Gapped input, in_valid held through CHECK/RESULT, ack with in_valid
    for (int t = 0; t < 4; t++) begin
      fill_happy();
      for (int i = 5; i < NB - 1; i++) fb[i] = 8'($urandom);
      if (t == 2) fb[$urandom_range(0, 4)] = 8'h00;
      secret = model_word();
      if (t == 3) secret[$urandom_range(0, 255)] ^= 1'b1;
      send_n(NB, 1'b1, 1'b1, fe);
      check_verdict("gapped", fe, 1'b0);
      finish_ack("gapped", 5, 1'b1);
    end

    // Reset after 17 bytes, then a clean load
    fill_happy();
    for (int i = 0; i < NB; i++) fb[i] = 8'($urandom);
    send_n(17, 1'b0, 1'b0, fe);
    chk("midload_busy", busy, 1);
    do_reset("midload_rst");
    fill_happy();
    secret = model_word();
    send_n(NB, 1'b0, 1'b0, fe);
    check_verdict("after_midload", fe, 1'b1);
    finish_ack("after_midload", 1, 1'b0);

    // Reset in CHECK, then a clean load
    fb[7] = 8'h5A;
    send_n(NB, 1'b0, 1'b0, fe);
    chk("midcheck_flag_valid", flag_valid, 1);
    chk("midcheck_res_valid", res_valid, 0);
    do_reset("midcheck_rst");
    fill_happy();
    fb[12] = 8'h30;
    secret = HAPPY;
    send_n(NB, 1'b0, 1'b0, fe);
    check_verdict("after_midcheck", fe, 1'b1);
    finish_ack("after_midcheck", 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
